data_sync_pulse: RTL and testbench

//   Carries a multi-bit bus from a foreign clock domain into the CLK domain.

---
 rtl/data_sync_pulse.sv | 64 ++++++
 tb/tb_data_sync_pulse.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/data_sync_pulse.sv
// data_sync_pulse: moves a bus into the CLK domain through one synchronized
// qualifier. Ports: CLK, RST (async low), UNSYNC_BUS, BUS_ENABLE in; SYNC_BUS,
// ENABLE_PULSE, XFER_COUNT out (all registered).
module data_sync_pulse #(
  parameter int BUS_WIDTH  = 8,
  parameter int NUM_STAGES = 2,
  parameter int PULSE_MODE = 0
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BUS_WIDTH-1:0] UNSYNC_BUS,
  input  logic                 BUS_ENABLE,
  output logic [BUS_WIDTH-1:0] SYNC_BUS,
  output logic                 ENABLE_PULSE,
  output logic [7:0]           XFER_COUNT
);

  logic [NUM_STAGES-1:0] en_s_q, en_s_d;
  logic                  en_prev_q, en_prev_d;
  logic [BUS_WIDTH-1:0]  sync_bus_q, sync_bus_d;
  logic                  pulse_q, pulse_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  en_sync;
  logic                  evt;

  assign en_sync = en_s_q[NUM_STAGES-1];

  always_comb begin
    en_s_d     = {en_s_q[NUM_STAGES-2:0], BUS_ENABLE};
    en_prev_d  = en_sync;
    evt        = (PULSE_MODE == 0) ? (en_sync & ~en_prev_q)
                                   : (en_sync ^ en_prev_q);
    sync_bus_d = sync_bus_q;
    cnt_d      = cnt_q;
    pulse_d    = evt;
    if (evt) begin
      // bus is quiet by now: the source holds it until the
      // qualifier has crossed the chain
      sync_bus_d = UNSYNC_BUS;
      cnt_d      = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      en_s_q     <= '0;
      en_prev_q  <= 1'b0;
      sync_bus_q <= '0;
      pulse_q    <= 1'b0;
      cnt_q      <= 8'd0;
    end else begin
      en_s_q     <= en_s_d;
      en_prev_q  <= en_prev_d;
      sync_bus_q <= sync_bus_d;
      pulse_q    <= pulse_d;
      cnt_q      <= cnt_d;
    end
  end

  assign SYNC_BUS     = sync_bus_q;
  assign ENABLE_PULSE = pulse_q;
  assign XFER_COUNT   = cnt_q;

endmodule

// File: tb/tb_data_sync_pulse.sv
// tb_data_sync_pulse: level (N=2) and toggle (N=3) instances,
// scoreboarded against pulses.
module tb_data_sync_pulse;

  typedef struct {
    logic [7:0] d;
    logic [7:0] c;
    int         e;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] bus_a = '0, bus_b = '0;
  logic       en_a = 1'b0, en_b = 1'b0;
  logic [7:0] sync_a, sync_b, cnt_a, cnt_b;
  logic       pul_a, pul_b;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t qa[$];
  exp_t qb[$];
  logic [7:0] mcnt_a = 0, mcnt_b = 0;

  always #5 clk = ~clk;

  data_sync_pulse #(.BUS_WIDTH(8), .NUM_STAGES(2), .PULSE_MODE(0)) u_a (
    .CLK(clk), .RST(rst), .UNSYNC_BUS(bus_a), .BUS_ENABLE(en_a),
    .SYNC_BUS(sync_a), .ENABLE_PULSE(pul_a), .XFER_COUNT(cnt_a)
  );

  data_sync_pulse #(.BUS_WIDTH(8), .NUM_STAGES(3), .PULSE_MODE(1)) u_b (
    .CLK(clk), .RST(rst), .UNSYNC_BUS(bus_b), .BUS_ENABLE(en_b),
    .SYNC_BUS(sync_b), .ENABLE_PULSE(pul_b), .XFER_COUNT(cnt_b)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_a(input logic [7:0] d);
    mcnt_a = mcnt_a + 8'd1;
    qa.push_back('{d, mcnt_a, cyc + 1 + 2});
  endtask

  task automatic push_b(input logic [7:0] d);
    mcnt_b = mcnt_b + 8'd1;
    qb.push_back('{d, mcnt_b, cyc + 1 + 3});
  endtask

  always begin
    exp_t e;
    @(posedge clk);
    cyc++;
    #1;
    if (pul_a) begin
      if (qa.size() == 0) begin
        chk("a_spurious", 32'(pul_a), 32'd0);
      end else begin
        e = qa.pop_front();
        chk("a_data", 32'(sync_a), 32'(e.d));
        chk("a_cnt", 32'(cnt_a), 32'(e.c));
        chk("a_lat", 32'(cyc), 32'(e.e));
      end
    end
    if (pul_b) begin
      if (qb.size() == 0) begin
        chk("b_spurious", 32'(pul_b), 32'd0);
      end else begin
        e = qb.pop_front();
        chk("b_data", 32'(sync_b), 32'(e.d));
        chk("b_cnt", 32'(cnt_b), 32'(e.c));
        chk("b_lat", 32'(cyc), 32'(e.e));
      end
    end
  end

  initial begin
    en_a  = 1'b1;
    bus_a = 8'hFF;
    en_b  = 1'b1;
    bus_b = 8'hFF;
    rst   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk("rst_sync_a", 32'(sync_a), 32'd0);
      chk("rst_pul_a", 32'(pul_a), 32'd0);
      chk("rst_cnt_a", 32'(cnt_a), 32'd0);
      chk("rst_sync_b", 32'(sync_b), 32'd0);
      chk("rst_cnt_b", 32'(cnt_b), 32'd0);
    end
    en_a = 1'b0;
    en_b = 1'b0;
    rst  = 1'b1;
    tick(4);

    bus_a = 8'hA5;
    en_a  = 1'b1;
    push_a(8'hA5);
    tick(10);
    chk("a_first", 32'(sync_a), 32'hA5);
    chk("a_cnt1", 32'(cnt_a), 32'd1);

    bus_a = 8'h3C;
    tick(6);
    chk("a_hold", 32'(sync_a), 32'hA5);
    chk("a_hold_cnt", 32'(cnt_a), 32'd1);
    en_a = 1'b0;
    tick(2);
    en_a = 1'b1;
    push_a(8'h3C);
    tick(10);
    chk("a_second", 32'(sync_a), 32'h3C);
    chk("a_cnt2", 32'(cnt_a), 32'd2);
    en_a = 1'b0;
    tick(4);

    for (int i = 1; i <= 4; i++) begin
      bus_b = 8'(i);
      en_b  = ~en_b;
      push_b(8'(i));
      tick(5);
    end
    tick(3);
    chk("b_final", 32'(sync_b), 32'h04);
    chk("b_cnt4", 32'(cnt_b), 32'd4);

    for (int i = 0; i < 256; i++) begin
      bus_b = 8'($urandom_range(0, 255));
      en_b  = ~en_b;
      push_b(bus_b);
      tick(5);
    end
    tick(3);
    chk("b_wrap_cnt", 32'(cnt_b), 32'd4);
    chk("b_left", 32'(qb.size()), 32'd0);
    chk("a_left", 32'(qa.size()), 32'd0);

    bus_a = 8'h77;
    en_a  = 1'b1;
    tick(1);
    rst    = 1'b0;
    en_a   = 1'b0;
    mcnt_a = 8'd0;
    mcnt_b = 8'd0;
    tick(3);
    rst = 1'b1;
    tick(8);
    chk("rst_mid_sync", 32'(sync_a), 32'd0);
    chk("rst_mid_cnt", 32'(cnt_a), 32'd0);
    chk("rst_mid_sync_b", 32'(sync_b), 32'd0);

    bus_a = 8'h5A;
    en_a  = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(3);
    rst = 1'b1;
    push_a(8'h5A);
    tick(8);
    chk("rst_hi_sync", 32'(sync_a), 32'h5A);
    chk("rst_hi_cnt", 32'(cnt_a), 32'd1);
    chk("a_left_end", 32'(qa.size()), 32'd0);
    chk("b_left_end", 32'(qb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
